// File: rtl/sym_butterfly_pkg.sv
// Shared constants, output-port state type and index helper for the
// butterfly switch-node allocator.
package sym_butterfly_pkg;

  localparam int unsigned RADIX      = 4;
  localparam int unsigned PORT_IDX_W = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } out_state_e;

  // Next port index, wrapping RADIX-1 back to 0.
  function automatic logic [PORT_IDX_W-1:0] next_idx(input logic [PORT_IDX_W-1:0] idx);
    return idx + PORT_IDX_W'(1);
  endfunction

endpackage

// File: rtl/rr_arb_4.sv
// Four-request round-robin picker: the first set request at or after ptr
// (mod 4) wins, reported one-hot and as an index.
module rr_arb_4
  import sym_butterfly_pkg::PORT_IDX_W;
(
  input  logic [3:0]            req,
  input  logic [PORT_IDX_W-1:0] ptr,
  output logic [3:0]            gnt,
  output logic [PORT_IDX_W-1:0] idx
);

  logic [PORT_IDX_W-1:0] cand;
  logic                  found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cand = ptr + PORT_IDX_W'(k);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/switch_node_alloc.sv
// Per-output wormhole allocator for one butterfly switch node: each output
// locks to one input for a whole packet and passes flits while ready.
module switch_node_alloc #(
  parameter int unsigned RADIX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [RADIX-1:0]      req_valid,
  input  logic [RADIX-1:0][1:0] req_dest,
  input  logic [RADIX-1:0]      req_tail,
  input  logic [RADIX-1:0]      out_ready,
  output logic [RADIX-1:0]      grant,
  output logic [RADIX-1:0][1:0] out_sel,
  output logic [RADIX-1:0]      out_valid
);

  import sym_butterfly_pkg::PORT_IDX_W;
  import sym_butterfly_pkg::out_state_e;
  import sym_butterfly_pkg::IDLE;
  import sym_butterfly_pkg::LOCKED;
  import sym_butterfly_pkg::next_idx;

  out_state_e            state_q  [RADIX];
  out_state_e            state_d  [RADIX];
  logic [PORT_IDX_W-1:0] owner_q  [RADIX];
  logic [PORT_IDX_W-1:0] owner_d  [RADIX];
  logic [PORT_IDX_W-1:0] ptr_q    [RADIX];
  logic [PORT_IDX_W-1:0] ptr_d    [RADIX];

  logic [RADIX-1:0]      owns_lock  [RADIX];
  logic [RADIX-1:0]      blocked    [RADIX];
  logic [RADIX-1:0]      dest_match [RADIX];
  logic [RADIX-1:0]      req_vec    [RADIX];
  logic [RADIX-1:0]      win_onehot [RADIX];
  logic [PORT_IDX_W-1:0] win_idx    [RADIX];
  logic [RADIX-1:0]      xfer;

  // Which input currently holds each LOCKED output.
  always_comb begin
    for (int o = 0; o < RADIX; o++) begin
      owns_lock[o] = '0;
      if (state_q[o] == LOCKED) begin
        owns_lock[o][owner_q[o]] = 1'b1;
      end
    end
  end

  // An input already holding some other output cannot request a second one.
  always_comb begin
    for (int o = 0; o < RADIX; o++) begin
      blocked[o]    = '0;
      dest_match[o] = '0;
      for (int o2 = 0; o2 < RADIX; o2++) begin
        if (o2 != o) begin
          blocked[o] = blocked[o] | owns_lock[o2];
        end
      end
      for (int i = 0; i < RADIX; i++) begin
        dest_match[o][i] = (req_dest[i] == PORT_IDX_W'(o));
      end
      req_vec[o] = req_valid & dest_match[o] & ~blocked[o];
    end
  end

  for (genvar g = 0; g < RADIX; g++) begin : g_arb
    rr_arb_4 u_arb (
      .req (req_vec[g]),
      .ptr (ptr_q[g]),
      .gnt (win_onehot[g]),
      .idx (win_idx[g])
    );
  end

  // Per-output next state plus combinational grant/valid/select.
  always_comb begin
    grant     = '0;
    out_valid = '0;
    out_sel   = '0;
    xfer      = '0;
    for (int o = 0; o < RADIX; o++) begin
      state_d[o] = state_q[o];
      owner_d[o] = owner_q[o];
      ptr_d[o]   = ptr_q[o];
      if (!rst) begin
        out_sel[o] = owner_q[o];
      end
      if (state_q[o] == IDLE) begin
        // Arbitration only; the winner's first flit moves next cycle.
        if (|win_onehot[o]) begin
          state_d[o] = LOCKED;
          owner_d[o] = win_idx[o];
        end
      end else begin
        xfer[o] = req_valid[owner_q[o]] && out_ready[o] &&
                  (req_dest[owner_q[o]] == PORT_IDX_W'(o));
        if (xfer[o] && !rst) begin
          grant[owner_q[o]] = 1'b1;
          out_valid[o]      = 1'b1;
        end
        if (xfer[o] && req_tail[owner_q[o]]) begin
          state_d[o] = IDLE;
          ptr_d[o]   = next_idx(owner_q[o]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int o = 0; o < RADIX; o++) begin
        state_q[o] <= IDLE;
        owner_q[o] <= '0;
        ptr_q[o]   <= '0;
      end
    end else begin
      for (int o = 0; o < RADIX; o++) begin
        state_q[o] <= state_d[o];
        owner_q[o] <= owner_d[o];
        ptr_q[o]   <= ptr_d[o];
      end
    end
  end

endmodule

// File: tb/tb_switch_node_alloc.sv
// Randomized and directed bench for switch_node_alloc: a packet-level
// reference model feeds an expectation queue that a negedge monitor drains.
module tb_switch_node_alloc;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      req_valid;
  logic [3:0][1:0] req_dest;
  logic [3:0]      req_tail;
  logic [3:0]      out_ready;
  logic [3:0]      grant;
  logic [3:0][1:0] out_sel;
  logic [3:0]      out_valid;

  switch_node_alloc #(.RADIX(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_dest  (req_dest),
    .req_tail  (req_tail),
    .out_ready (out_ready),
    .grant     (grant),
    .out_sel   (out_sel),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]      g;
    logic [3:0]      ov;
    logic [3:0][1:0] sel;
  } exp_t;

  typedef struct packed {
    logic [1:0] dest;
    logic [7:0] len;
  } pkt_t;

  exp_t       exp_q[$];
  logic [3:0] grant_hist[$];
  exp_t       last_exp;
  exp_t       mon_e;
  int         n_tests = 0;
  int         n_fail  = 0;
  int         tick_n  = 0;
  int         mon_cnt;

  // Reference model: per output, locked flag, owning input and pointer.
  int m_locked[4];
  int m_own[4];
  int m_ptr[4];

  // Packet sources: queued packets and the packet currently being sent.
  pkt_t       pq[4][$];
  int         rem[4];
  logic [1:0] cdest[4];

  int         p_valid = 100;
  int         p_ready = 100;
  logic [3:0] ready_force_low = '0;
  logic       rst_next = 1'b1;

  function automatic bool_holds_other(input int i, input int o);
    for (int o2 = 0; o2 < 4; o2++)
      if (o2 != o && m_locked[o2] != 0 && m_own[o2] == i) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic flit_moves(input int o);
    int i;
    i = m_own[o];
    return m_locked[o] != 0 && req_valid[i] && out_ready[o] && int'(req_dest[i]) == o;
  endfunction

  // Advance the model across one rising edge using the inputs held before it.
  task automatic model_edge();
    int nl[4], no[4], np[4];
    bit found;
    int cand;
    if (rst) begin
      for (int o = 0; o < 4; o++) begin
        m_locked[o] = 0; m_own[o] = 0; m_ptr[o] = 0;
      end
      return;
    end
    for (int o = 0; o < 4; o++) begin
      nl[o] = m_locked[o]; no[o] = m_own[o]; np[o] = m_ptr[o];
      if (m_locked[o] != 0) begin
        if (flit_moves(o) && req_tail[m_own[o]]) begin
          nl[o] = 0;
          np[o] = (m_own[o] + 1) % 4;
        end
      end else begin
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
          cand = (m_ptr[o] + k) % 4;
          if (!found && req_valid[cand] && int'(req_dest[cand]) == o &&
              !bool_holds_other(cand, o)) begin
            found = 1'b1; nl[o] = 1; no[o] = cand;
          end
        end
      end
    end
    for (int o = 0; o < 4; o++) begin
      m_locked[o] = nl[o]; m_own[o] = no[o]; m_ptr[o] = np[o];
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e = '0;
    if (rst) return e;
    for (int o = 0; o < 4; o++) begin
      e.sel[o] = 2'(m_own[o]);
      if (flit_moves(o)) begin
        e.g[m_own[o]] = 1'b1;
        e.ov[o]       = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic src_edge();
    pkt_t p;
    for (int i = 0; i < 4; i++) begin
      if (last_exp.g[i]) rem[i] = rem[i] - 1;
      if (rem[i] == 0 && pq[i].size() > 0) begin
        p = pq[i].pop_front();
        rem[i]   = int'(p.len);
        cdest[i] = p.dest;
      end
    end
  endtask

  task automatic drive();
    rst = rst_next;
    for (int i = 0; i < 4; i++) begin
      if (rem[i] > 0) begin
        req_valid[i] = ($urandom_range(99) < p_valid);
        req_dest[i]  = cdest[i];
        req_tail[i]  = (rem[i] == 1);
      end else begin
        req_valid[i] = 1'b0;
        req_dest[i]  = 2'($urandom_range(3));
        req_tail[i]  = 1'($urandom_range(1));
      end
    end
    for (int o = 0; o < 4; o++)
      out_ready[o] = !ready_force_low[o] && ($urandom_range(99) < p_ready);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    model_edge();
    src_edge();
    drive();
    e = model_out();
    exp_q.push_back(e);
    last_exp = e;
    tick_n++;
  endtask

  function automatic bit sources_busy();
    for (int i = 0; i < 4; i++)
      if (rem[i] > 0 || pq[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sources_busy() && n < 2000) begin
      tick();
      n++;
    end
    if (sources_busy()) begin
      n_tests++; n_fail++;
      $display("FAIL drain_%s: packets still pending after %0d cycles, required none", name, n);
    end
  endtask

  task automatic do_reset(input int n);
    rst_next = 1'b1;
    repeat (n) tick();
    rst_next = 1'b0;
  endtask

  // Cycle c of a scenario whose cycle 1 was tick t1 sits at hist[t1+c-2].
  task automatic check_hist(input string name, input int t1, input int c, input logic [3:0] want);
    int idx;
    idx = t1 + c - 2;
    n_tests++;
    if (idx >= grant_hist.size()) begin
      n_fail++;
      $display("FAIL %s c%0d: no monitor record, required grant=%b", name, c, want);
    end else if (grant_hist[idx] !== want) begin
      n_fail++;
      $display("FAIL %s c%0d: grant=%b required %b", name, c, grant_hist[idx], want);
    end
  endtask

  // Monitor: compare against the queued expectation and check invariants.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      grant_hist.push_back(grant);
      n_tests++;
      if (grant !== mon_e.g) begin
        n_fail++;
        $display("FAIL grant t=%0t: got %b required %b", $time, grant, mon_e.g);
      end
      n_tests++;
      if (out_valid !== mon_e.ov) begin
        n_fail++;
        $display("FAIL out_valid t=%0t: got %b required %b", $time, out_valid, mon_e.ov);
      end
      n_tests++;
      if (out_sel !== mon_e.sel) begin
        n_fail++;
        $display("FAIL out_sel t=%0t: got %h required %h", $time, out_sel, mon_e.sel);
      end
      for (int i = 0; i < 4; i++) begin
        mon_cnt = 0;
        for (int o = 0; o < 4; o++)
          if (out_valid[o] && int'(out_sel[o]) == i) mon_cnt++;
        n_tests++;
        if (mon_cnt != (grant[i] ? 1 : 0)) begin
          n_fail++;
          $display("FAIL grant_source in%0d t=%0t: %0d driving outputs with grant=%b, required %0d",
                   i, $time, mon_cnt, grant[i], grant[i] ? 1 : 0);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1;
    pkt_t p;
    logic [3:0] want;
    rst = 1'b1; req_valid = '0; req_dest = '0; req_tail = '0; out_ready = '0;
    last_exp = '0;
    for (int k = 0; k < 4; k++) begin
      m_locked[k] = 0; m_own[k] = 0; m_ptr[k] = 0; rem[k] = 0; cdest[k] = '0;
    end

    // Two 3-flit packets contending for output 1 right after reset.
    do_reset(3);
    pq[0].push_back('{2'd1, 8'd3});
    pq[2].push_back('{2'd1, 8'd3});
    t1 = tick_n + 1;
    drain("two_pkts");
    tick();
    @(negedge clk); #1;
    for (int c = 1; c <= 9; c++) begin
      want = (c >= 2 && c <= 4) ? 4'b0001 : ((c >= 6 && c <= 8) ? 4'b0100 : 4'b0000);
      check_hist("two_pkts", t1, c, want);
    end

    // Single-flit packets from every input to output 3, two rounds.
    do_reset(2);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++) pq[i].push_back('{2'd3, 8'd1});
    t1 = tick_n + 1;
    drain("rr_wrap");
    tick();
    @(negedge clk); #1;
    for (int c = 1; c <= 17; c++) begin
      want = '0;
      if (c >= 2 && c <= 16 && (c % 2) == 0) want[((c - 2) / 2) % 4] = 1'b1;
      check_hist("rr_wrap", t1, c, want);
    end

    // All four inputs to distinct outputs at once.
    do_reset(2);
    for (int i = 0; i < 4; i++) begin
      p.dest = 2'(3 - i); p.len = 8'd2;
      pq[i].push_back(p);
    end
    t1 = tick_n + 1;
    drain("parallel");
    tick();
    @(negedge clk); #1;
    check_hist("parallel", t1, 2, 4'b1111);
    check_hist("parallel", t1, 3, 4'b1111);

    // Output 2 stalls for 5 cycles in the middle of a 6-flit packet.
    do_reset(2);
    pq[1].push_back('{2'd2, 8'd6});
    t1 = tick_n + 1;
    tick(); tick();
    ready_force_low = 4'b0100;
    repeat (5) tick();
    ready_force_low = '0;
    drain("stall");
    tick();
    @(negedge clk); #1;
    for (int c = 2; c <= 13; c++) begin
      want = (c == 2 || (c >= 8 && c <= 12)) ? 4'b0010 : 4'b0000;
      check_hist("stall", t1, c, want);
    end

    // Reset pulse while flit 2 of a 4-flit packet is offered.
    do_reset(2);
    pq[0].push_back('{2'd0, 8'd4});
    t1 = tick_n + 1;
    tick(); tick();
    rst_next = 1'b1;
    tick();
    rst_next = 1'b0;
    drain("mid_reset");
    tick();
    @(negedge clk); #1;
    for (int c = 1; c <= 8; c++) begin
      want = (c == 2 || (c >= 5 && c <= 7)) ? 4'b0001 : 4'b0000;
      check_hist("mid_reset", t1, c, want);
    end

    // Random traffic with backpressure, bubbles and occasional resets.
    p_valid = 75;
    p_ready = 70;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(3) == 0) begin
        int i;
        i = $urandom_range(3);
        if (pq[i].size() < 3) begin
          p.dest = 2'($urandom_range(3));
          p.len  = 8'($urandom_range(4, 1));
          pq[i].push_back(p);
        end
      end
      rst_next = ($urandom_range(199) == 0);
      tick();
    end
    rst_next = 1'b0;
    drain("random");
    repeat (2) tick();
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
